act_mem_pingpong_banked: RTL and testbench
==========================================

// Module: act_mem_pingpong_banked
// PURPOSE
//  Parametrised ping-pong activation memory between the PE array and the external load/store port.
//  Two regions: one is the input region (core reads), the other the output region (core writes).
//  Adds masked writes, a handshaked region swap, and sliding-window reads at any element offset.
//  Such a read may span two rows; the block fetches both and realigns the elements.
//  An external port can reach either region; the core wins any per-region collision.
// PARAMETERS
//  N_DIM       4    elements per row (power of 2, >=2); LOG_N = $clog2(N_DIM)
//  DATA_W      8    bits per element
//  ROW_ADDR_W  11   row address bits per region; rows per region = 2**ROW_ADDR_W
// PORTS
//  clk          in   1                  clock
//  reset        in   1                  asynchronous, active-low
//  rd_req       in   1                  core read request; accepted when rd_req & rd_ready
//  rd_addr      in   ROW_ADDR_W+LOG_N   element address within input region
//  rd_window    in   1                  1: realign to element rd_addr; 0: whole row rd_addr>>LOG_N
//  rd_ready     out  1                  core read can be accepted this cycle
//  rd_valid     out  1                  rd_data valid (one-cycle pulse per read)
//  rd_data      out  N_DIM*DATA_W       element j in bits [j*DATA_W +: DATA_W]
//  wr_en        in   1                  core write to output region (never stalled)
//  wr_row       in   ROW_ADDR_W         row within output region
//  wr_data      in   N_DIM*DATA_W       write data
//  wr_mask      in   N_DIM              per-element write enable
//  ext_req      in   1                  external access request
//  ext_we       in   1                  1 = write, 0 = read
//  ext_addr     in   ROW_ADDR_W+1       MSB = region, rest = row
//  ext_wdata    in   N_DIM*DATA_W       external write data (full row)
//  ext_gnt      out  1                  access performed this cycle
//  ext_rvalid   out  1                  ext_rdata valid, 1 cycle after granted read
//  ext_rdata    out  N_DIM*DATA_W       external read data
//  swap_req     in   1                  request input/output role exchange (level, held until swap_done)
//  swap_done    out  1                  one-cycle pulse when the roles have toggled
//  in_sel       out  1                  region currently used as input region
// BEHAVIOUR
//  Reset (async): in_sel=0, rd_ready=1, rd_valid=0, rd_data=0, ext_gnt=0, ext_rvalid=0, ext_rdata=0, swap_done=0.
//   Both FSMs go to their idle states. Memory contents are not reset.
//  Each region is single-port: at most one access per cycle. Core read -> region in_sel.
//   Core write -> region ~in_sel.
//  Read FSM R_IDLE/R_SECOND. Accepted read with rd_window=0 or rd_addr[LOG_N-1:0]==0 reads one row.
//   rd_valid is asserted the next cycle (latency 1). FSM stays R_IDLE.
//  Accepted read with rd_window=1 and offset off!=0 -> R_SECOND:
//   - Cycle 0 reads row r; cycle 1 reads row r+1 (mod 2**ROW_ADDR_W, wraps to row 0); rd_ready=0 during cycle 1.
//   - rd_valid is asserted one cycle after cycle 1 (latency 2).
//   - rd_data[j] = element (off+j) of the concatenation {row r+1, row r}.
//  Back-to-back aligned reads sustain one read per cycle.
//  Swap FSM S_RUN/S_DRAIN/S_SWAP.
//   - swap_req in S_RUN -> S_DRAIN; rd_ready=0 from that cycle, no new reads accepted.
//   - S_DRAIN -> S_SWAP once the read FSM is R_IDLE and no rd_valid is pending.
//   - S_SWAP: in_sel toggles and swap_done pulses for that single cycle; next cycle back to S_RUN with rd_ready=1.
//   - Writes are accepted in every swap state. A write issued in the S_SWAP cycle uses the pre-toggle output region.
//  Ext arbitration: ext_gnt=1 iff ext_req=1 and the target region has no core access this cycle.
//   Ungranted requests must be held stable by the requester. Granted writes apply the full row.
//  Reads of rows being written in the same cycle return the old data.
//  A core write and a granted ext write never target the same region in the same cycle.
//  Assertion: wr_en with wr_mask==0 is legal and writes nothing.
//  Reset asserted mid-read or mid-swap aborts the operation: no rd_valid, no swap_done, in_sel=0.
// TESTING
//  1 ext write rows 0..3 of region0 with element value = 4*row+j; core aligned read rd_addr=8
//    -> rd_valid 1 cycle later, data {11,10,9,8}.
//  2 same data, rd_window=1, rd_addr=6 -> rd_ready=0 one cycle; rd_valid at latency 2, data {9,8,7,6}.
//  3 last row wrap: rd_window=1, rd_addr=(2**ROW_ADDR_W)*N_DIM-1
//    -> data {elements 2,1,0 of row 0, last element of last row}.
//  4 core write wr_row=5, wr_mask=4'b0101, data {AA,BB,CC,DD}; ext read region1 row 5
//    -> only elements 0 and 2 updated (DD, BB).
//  5 ext read of region0 during continuous core reads -> ext_gnt=0 until rd_req drops, then gnt and rvalid next cycle.
//  6 swap_req during R_SECOND -> swap_done after that read's rd_valid; in_sel=1; reset mid-drain -> in_sel=0, no pulse.

Source files
------------

// File: rtl/act_mem_pingpong_banked.sv
// Ping-pong activation memory: two single-port regions swapped between input/output roles,
// with masked core writes, realigning window reads and an external port that yields to the core.
module act_mem_pingpong_banked #(
  parameter int N_DIM      = 4,
  parameter int DATA_W     = 8,
  parameter int ROW_ADDR_W = 11
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  rd_req,
  input  logic [ROW_ADDR_W+$clog2(N_DIM)-1:0]   rd_addr,
  input  logic                                  rd_window,
  output logic                                  rd_ready,
  output logic                                  rd_valid,
  output logic [N_DIM*DATA_W-1:0]               rd_data,
  input  logic                                  wr_en,
  input  logic [ROW_ADDR_W-1:0]                 wr_row,
  input  logic [N_DIM*DATA_W-1:0]               wr_data,
  input  logic [N_DIM-1:0]                      wr_mask,
  input  logic                                  ext_req,
  input  logic                                  ext_we,
  input  logic [ROW_ADDR_W:0]                   ext_addr,
  input  logic [N_DIM*DATA_W-1:0]               ext_wdata,
  output logic                                  ext_gnt,
  output logic                                  ext_rvalid,
  output logic [N_DIM*DATA_W-1:0]               ext_rdata,
  input  logic                                  swap_req,
  output logic                                  swap_done,
  output logic                                  in_sel
);

  localparam int LOG_N = $clog2(N_DIM);
  localparam int ROW_W = N_DIM * DATA_W;
  localparam int ROWS  = 2 ** ROW_ADDR_W;

  typedef enum logic {R_IDLE, R_SECOND} rd_state_t;
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SWAP} swap_state_t;

  logic [ROW_W-1:0] mem [2][ROWS];

  rd_state_t   rd_st, rd_st_nxt;
  swap_state_t sw_st, sw_st_nxt;

  logic [ROW_ADDR_W-1:0] rd_row, nxt_row, core_row_addr;
  logic [LOG_N-1:0]      rd_off, off_q;
  logic                  rd_accept, rd_split, core_rd_busy;
  logic [ROW_W-1:0]      core_row, lo_row, win_data;
  logic [2*ROW_W-1:0]    cat;

  logic                  ext_region;
  logic [ROW_ADDR_W-1:0] ext_row;

  logic [1:0]            w_en;
  logic [ROW_ADDR_W-1:0] w_row  [2];
  logic [ROW_W-1:0]      w_data [2];
  logic [N_DIM-1:0]      w_mask [2];

  // ---------------------------------------------------------------- core read path
  assign rd_row        = rd_addr[ROW_ADDR_W+LOG_N-1:LOG_N];
  assign rd_off        = rd_addr[LOG_N-1:0];
  assign rd_ready      = (sw_st == S_RUN) && !swap_req && (rd_st == R_IDLE);
  assign rd_accept     = rd_req && rd_ready;
  assign rd_split      = rd_window && (rd_off != '0);
  assign core_rd_busy  = rd_accept || (rd_st == R_SECOND);
  assign core_row_addr = (rd_st == R_SECOND) ? nxt_row : rd_row;
  assign core_row      = mem[in_sel][core_row_addr];

  // Second row sits in the upper half so element off+j is a plain forward index.
  assign cat = {core_row, lo_row};

  always_comb begin
    win_data = '0;
    for (int j = 0; j < N_DIM; j++) begin
      win_data[j*DATA_W +: DATA_W] = cat[(int'(off_q) + j)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rd_st_nxt = rd_st;
    case (rd_st)
      R_IDLE:   if (rd_accept && rd_split) rd_st_nxt = R_SECOND;
      R_SECOND: rd_st_nxt = R_IDLE;
      default:  rd_st_nxt = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- swap control
  // Drain waits for rd_valid to drop as well, so the last read is delivered before the roles flip.
  always_comb begin
    sw_st_nxt = sw_st;
    swap_done = 1'b0;
    case (sw_st)
      S_RUN:   if (swap_req) sw_st_nxt = S_DRAIN;
      S_DRAIN: if ((rd_st == R_IDLE) && !rd_valid) sw_st_nxt = S_SWAP;
      S_SWAP: begin
        swap_done = 1'b1;
        sw_st_nxt = S_RUN;
      end
      default: sw_st_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_st  <= R_IDLE;
      sw_st  <= S_RUN;
      in_sel <= 1'b0;
    end else begin
      rd_st <= rd_st_nxt;
      sw_st <= sw_st_nxt;
      if (sw_st == S_SWAP) in_sel <= ~in_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      lo_row   <= '0;
      nxt_row  <= '0;
      off_q    <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_st == R_SECOND) begin
        rd_data  <= win_data;
        rd_valid <= 1'b1;
      end else if (rd_accept) begin
        if (rd_split) begin
          lo_row  <= core_row;
          nxt_row <= rd_row + 1'b1;
          off_q   <= rd_off;
        end else begin
          rd_data  <= core_row;
          rd_valid <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- external port
  assign ext_region = ext_addr[ROW_ADDR_W];
  assign ext_row    = ext_addr[ROW_ADDR_W-1:0];
  assign ext_gnt    = ext_req && !((ext_region == in_sel) ? core_rd_busy : wr_en);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      ext_rvalid <= ext_gnt && !ext_we;
      if (ext_gnt && !ext_we) ext_rdata <= mem[ext_region][ext_row];
    end
  end

  // ---------------------------------------------------------------- region write ports
  // The arbiter keeps a core write and a granted ext write off the same region.
  always_comb begin
    w_en      = '0;
    w_row[0]  = '0;
    w_row[1]  = '0;
    w_data[0] = '0;
    w_data[1] = '0;
    w_mask[0] = '0;
    w_mask[1] = '0;
    if (wr_en) begin
      w_en[~in_sel]   = 1'b1;
      w_row[~in_sel]  = wr_row;
      w_data[~in_sel] = wr_data;
      w_mask[~in_sel] = wr_mask;
    end
    if (ext_gnt && ext_we) begin
      w_en[ext_region]   = 1'b1;
      w_row[ext_region]  = ext_row;
      w_data[ext_region] = ext_wdata;
      w_mask[ext_region] = '1;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < N_DIM; j++) begin
      if (w_en[0] && w_mask[0][j])
        mem[0][w_row[0]][j*DATA_W +: DATA_W] <= w_data[0][j*DATA_W +: DATA_W];
      if (w_en[1] && w_mask[1][j])
        mem[1][w_row[1]][j*DATA_W +: DATA_W] <= w_data[1][j*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_act_mem_pingpong_banked.sv
// Scoreboard bench for act_mem_pingpong_banked: expected read data queued at issue, checked on valid.
module tb_act_mem_pingpong_banked;

  logic        clk;
  logic        reset;
  logic        rd_req;
  logic [12:0] rd_addr;
  logic        rd_window;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [10:0] wr_row;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        ext_req;
  logic        ext_we;
  logic [11:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;
  logic        swap_req;
  logic        swap_done;
  logic        in_sel;

  act_mem_pingpong_banked #(.N_DIM(4), .DATA_W(8), .ROW_ADDR_W(11)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_window(rd_window), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .wr_mask(wr_mask),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .swap_req(swap_req), .swap_done(swap_done), .in_sel(in_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        rd_q[$];
  exp_t        ext_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_rdv_cyc = -1;
  bit          saw_done = 1'b0;
  logic        exp_in_sel;
  logic [31:0] model [2][2048];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_valid) begin
      if (rd_q.size() == 0) check("rd_unexpected_valid", 32'(rd_valid), 32'd0);
      else begin
        e = rd_q.pop_front();
        check("rd_data", rd_data, e.data);
        check("rd_latency", cyc, e.due);
      end
      last_rdv_cyc = cyc;
    end
    if (ext_rvalid) begin
      if (ext_q.size() == 0) check("ext_unexpected_rvalid", 32'(ext_rvalid), 32'd0);
      else begin
        e = ext_q.pop_front();
        check("ext_rdata", ext_rdata, e.data);
        check("ext_latency", cyc, e.due);
      end
    end
    if (swap_done) saw_done = 1'b1;
  end

  function automatic logic [31:0] pack(input int row);
    logic [31:0] p;
    for (int j = 0; j < 4; j++) p[j*8 +: 8] = 8'((4*row + j) & 255);
    return p;
  endfunction

  function automatic logic [31:0] exp_read(input logic [12:0] addr, input logic window);
    logic [10:0] r;
    logic [1:0]  off;
    logic [63:0] c;
    r   = addr[12:2];
    off = addr[1:0];
    c   = {model[exp_in_sel][r + 11'd1], model[exp_in_sel][r]};
    if (!window || off == 2'd0) return model[exp_in_sel][r];
    return c[off*8 +: 32];
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic ext_access(input logic we, input logic region, input logic [10:0] row,
                            input logic [31:0] wdata, input logic [31:0] exp);
    bit ok = 1'b0;
    ext_req = 1'b1; ext_we = we; ext_addr = {region, row}; ext_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ext_gnt) begin ok = 1'b1; break; end
    end
    check("ext_grant", 32'(ok), 32'd1);
    if (ok && !we) ext_q.push_back('{exp, cyc + 1});
    @(posedge clk); #1;
    ext_req = 1'b0; ext_we = 1'b0;
    if (ok && we) model[region][row] = wdata;
  endtask

  task automatic core_read(input logic [12:0] addr, input logic window, input logic [31:0] exp);
    bit ok = 1'b0;
    bit split;
    split = window && (addr[1:0] != 2'd0);
    rd_req = 1'b1; rd_addr = addr; rd_window = window;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_ready) begin ok = 1'b1; break; end
    end
    check("rd_accept", 32'(ok), 32'd1);
    if (ok) rd_q.push_back('{exp, cyc + (split ? 2 : 1)});
    @(posedge clk); #1;
    rd_req = 1'b0;
    if (ok && split) begin
      @(negedge clk);
      check("rd_ready_second_cycle", 32'(rd_ready), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10; i++) begin
      if (rd_q.size() == 0 && ext_q.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk); #1;
    check("queues_drained", 32'(rd_q.size() + ext_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    bit done;
    reset = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_window = 1'b0;
    wr_en = 1'b0; wr_row = '0; wr_data = '0; wr_mask = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    swap_req = 1'b0; exp_in_sel = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_sel",     32'(in_sel),     32'd0);
    check("rst_rd_ready",   32'(rd_ready),   32'd1);
    check("rst_rd_valid",   32'(rd_valid),   32'd0);
    check("rst_rd_data",    rd_data,         32'd0);
    check("rst_ext_rvalid", 32'(ext_rvalid), 32'd0);
    check("rst_ext_rdata",  ext_rdata,       32'd0);
    check("rst_swap_done",  32'(swap_done),  32'd0);
    @(posedge clk); #1 reset = 1'b1;

    for (int r = 0; r < 4; r++) ext_access(1'b1, 1'b0, 11'(r), pack(r), '0);
    ext_access(1'b1, 1'b0, 11'd2047, pack(2047), '0);
    ext_access(1'b1, 1'b1, 11'd5, 32'h11223344, '0);
    ext_access(1'b1, 1'b1, 11'd6, 32'h55667788, '0);
    ext_access(1'b1, 1'b0, 11'd8, 32'hCAFEF00D, '0);
    ext_access(1'b1, 1'b1, 11'd8, 32'h00000000, '0);

    // aligned, window with zero offset, split window, last-row wrap
    core_read(13'd8, 1'b0, 32'h0B0A0908);
    core_read(13'd8, 1'b1, 32'h0B0A0908);
    core_read(13'd6, 1'b1, 32'h09080706);
    core_read(13'd8191, 1'b1, 32'h020100FF);
    wait_idle();

    // masked write, zero-mask write, ext blocked by a core write to the same region
    wr_en = 1'b1; wr_row = 11'd5; wr_mask = 4'b0101; wr_data = 32'hAABBCCDD;
    @(posedge clk); #1;
    wr_row = 11'd6; wr_mask = 4'b0000; wr_data = 32'hFFFFFFFF;
    @(posedge clk); #1;
    model[1][5] = 32'h11BB33DD;
    wr_row = 11'd9; ext_req = 1'b1; ext_we = 1'b0; ext_addr = {1'b1, 11'd5};
    @(negedge clk);
    check("t4_gnt_blocked_by_wr", 32'(ext_gnt), 32'd0);
    @(posedge clk); #1 wr_en = 1'b0;
    @(negedge clk);
    check("t4_gnt_after_wr", 32'(ext_gnt), 32'd1);
    ext_q.push_back('{32'h11BB33DD, cyc + 1});
    @(posedge clk); #1 ext_req = 1'b0;
    ext_access(1'b0, 1'b1, 11'd6, '0, 32'h55667788);
    wait_idle();

    // ext read of the input region starved by a continuous aligned read stream
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = {1'b0, 11'd2};
    for (int i = 0; i < 6; i++) begin
      rd_req = 1'b1; rd_window = 1'b0; rd_addr = 13'((i % 4) * 4);
      @(negedge clk);
      check("t5_rd_ready", 32'(rd_ready), 32'd1);
      check("t5_gnt_blocked", 32'(ext_gnt), 32'd0);
      rd_q.push_back('{pack(i % 4), cyc + 1});
      @(posedge clk); #1;
    end
    rd_req = 1'b0;
    @(negedge clk);
    check("t5_gnt", 32'(ext_gnt), 32'd1);
    ext_q.push_back('{pack(2), cyc + 1});
    @(posedge clk); #1 ext_req = 1'b0;
    wait_idle();

    // swap requested during the second cycle of a split read, writes flowing throughout
    last_rdv_cyc = -1;
    rd_req = 1'b1; rd_addr = 13'd6; rd_window = 1'b1;
    @(negedge clk);
    check("t6_rd_ready", 32'(rd_ready), 32'd1);
    rd_q.push_back('{32'h09080706, cyc + 2});
    @(posedge clk); #1;
    rd_req = 1'b0; swap_req = 1'b1; wr_en = 1'b1; wr_row = 11'd8; wr_mask = 4'hF;
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      wr_data = 32'hD0000000 + 32'(k);
      @(negedge clk);
      if (k == 0) check("t6_ready_on_swap_req", 32'(rd_ready), 32'd0);
      model[!exp_in_sel][8] = wr_data;
      if (swap_done) begin
        check("t6_rdvalid_before_done", 32'(last_rdv_cyc >= 0 && last_rdv_cyc < cyc), 32'd1);
        check("t6_rdq_empty_at_done", 32'(rd_q.size()), 32'd0);
        exp_in_sel = ~exp_in_sel;
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("t6_swap_done_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
    wr_en = 1'b0; swap_req = 1'b0; wr_mask = '0;
    @(negedge clk);
    check("t6_in_sel", 32'(in_sel), 32'd1);
    check("t6_ready_after_swap", 32'(rd_ready), 32'd1);
    check("t6_done_single_pulse", 32'(swap_done), 32'd0);
    @(posedge clk); #1;
    ext_access(1'b0, 1'b1, 11'd8, '0, model[1][8]);
    ext_access(1'b0, 1'b0, 11'd8, '0, 32'hCAFEF00D);
    core_read(13'd20, 1'b0, 32'h11BB33DD);
    wait_idle();

    // reset during drain: no pulse, in_sel back to region 0
    saw_done = 1'b0;
    rd_req = 1'b1; rd_addr = 13'd22; rd_window = 1'b1;
    @(negedge clk);
    check("t7_rd_ready", 32'(rd_ready), 32'd1);
    rd_q.push_back('{exp_read(13'd22, 1'b1), cyc + 2});
    @(posedge clk); #1;
    rd_req = 1'b0; swap_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; swap_req = 1'b0; exp_in_sel = 1'b0;
    @(negedge clk);
    check("t7_in_sel_reset", 32'(in_sel), 32'd0);
    check("t7_swap_done_reset", 32'(swap_done), 32'd0);
    check("t7_rd_ready_reset", 32'(rd_ready), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t7_no_swap_done", 32'(saw_done), 32'd0);
    check("t7_in_sel_after", 32'(in_sel), 32'd0);
    check("t7_rdq_empty", 32'(rd_q.size()), 32'd0);

    // reset during the second cycle of a split read: the read is dropped
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 13'd6; rd_window = 1'b1;
    @(negedge clk);
    check("t8_rd_ready", 32'(rd_ready), 32'd1);
    @(posedge clk); #1;
    rd_req = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("t8_no_valid_a", 32'(rd_valid), 32'd0);
    @(negedge clk);
    check("t8_no_valid_b", 32'(rd_valid), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    core_read(13'd4, 1'b0, pack(1));
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
